// File: rtl/rs_alu_issue_pkg.sv
// Shared definitions for the ALU reservation station: opcode codes and
// default geometry.
package rs_alu_issue_pkg;

  localparam int RS_ENTRIES_DEF = 8;
  localparam int ROB_W_DEF      = 4;
  localparam int OPCODE_W       = 6;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_JAL, OP_JALR
  } alu_op_e;

endpackage

// File: rtl/rs_alu_issue_pick.sv
// Lowest-index priority picker: reports whether any request is set and
// the encoded index of the lowest one.
module rs_pick #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Descending scan so the lowest set bit is the last to write idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rs_alu_issue.sv
// ALU reservation station: holds dispatched micro-ops until both operands
// are known, snoops both CDBs, and issues one ready entry per cycle.
module rs_alu_issue
  import rs_alu_issue_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             disp_valid,
  input  logic [5:0]       disp_opcode,
  input  logic [31:0]      disp_vj,
  input  logic [31:0]      disp_vk,
  input  logic             disp_qj_valid,
  input  logic             disp_qk_valid,
  input  logic [ROB_W-1:0] disp_qj,
  input  logic [ROB_W-1:0] disp_qk,
  input  logic [31:0]      disp_imm,
  input  logic [31:0]      disp_pc,
  input  logic [ROB_W-1:0] disp_rob,
  output logic             full,
  input  logic             cdb_alu_valid,
  input  logic [ROB_W-1:0] cdb_alu_rob,
  input  logic [31:0]      cdb_alu_value,
  input  logic             cdb_lsb_valid,
  input  logic [ROB_W-1:0] cdb_lsb_rob,
  input  logic [31:0]      cdb_lsb_value,
  output logic             alu_sgn,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_lhs,
  output logic [31:0]      alu_rhs,
  output logic [31:0]      alu_imm,
  output logic [31:0]      alu_pc,
  output logic [ROB_W-1:0] alu_rob
);

  localparam int IW = $clog2(ENTRIES);
  localparam int CW = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] busy_q, busy_d, qjv_q, qjv_d, qkv_q, qkv_d;
  logic [5:0]         op_q  [ENTRIES];
  logic [5:0]         op_d  [ENTRIES];
  logic [31:0]        vj_q  [ENTRIES];
  logic [31:0]        vj_d  [ENTRIES];
  logic [31:0]        vk_q  [ENTRIES];
  logic [31:0]        vk_d  [ENTRIES];
  logic [ROB_W-1:0]   qj_q  [ENTRIES];
  logic [ROB_W-1:0]   qj_d  [ENTRIES];
  logic [ROB_W-1:0]   qk_q  [ENTRIES];
  logic [ROB_W-1:0]   qk_d  [ENTRIES];
  logic [31:0]        imm_q [ENTRIES];
  logic [31:0]        imm_d [ENTRIES];
  logic [31:0]        pc_q  [ENTRIES];
  logic [31:0]        pc_d  [ENTRIES];
  logic [ROB_W-1:0]   rob_q [ENTRIES];
  logic [ROB_W-1:0]   rob_d [ENTRIES];
  logic [CW-1:0]      count_q, count_d;

  logic             alu_sgn_q, alu_sgn_d;
  logic [5:0]       alu_opcode_q, alu_opcode_d;
  logic [31:0]      alu_lhs_q, alu_lhs_d, alu_rhs_q, alu_rhs_d;
  logic [31:0]      alu_imm_q, alu_imm_d, alu_pc_q, alu_pc_d;
  logic [ROB_W-1:0] alu_rob_q, alu_rob_d;

  logic [ENTRIES-1:0] ready;
  logic               free_found, rdy_found, accept, issue;
  logic [IW-1:0]      free_idx, rdy_idx;
  logic               dj_pend, dk_pend;
  logic [31:0]        dj_val, dk_val;

  assign ready = busy_q & ~qjv_q & ~qkv_q;
  assign full  = (count_q == CW'(ENTRIES));

  rs_pick #(.N(ENTRIES), .IW(IW)) u_free_pick (
    .req(~busy_q), .found(free_found), .idx(free_idx)
  );

  rs_pick #(.N(ENTRIES), .IW(IW)) u_ready_pick (
    .req(ready), .found(rdy_found), .idx(rdy_idx)
  );

  assign accept = disp_valid & ~full & free_found & rdy & ~flush;
  assign issue  = rdy_found & rdy & ~flush;

  // Dispatch-cycle bypass; the ALU bus has priority over the LSB bus.
  always_comb begin
    dj_pend = disp_qj_valid;
    dj_val  = disp_vj;
    dk_pend = disp_qk_valid;
    dk_val  = disp_vk;
    if (disp_qj_valid && cdb_alu_valid && disp_qj == cdb_alu_rob) begin
      dj_pend = 1'b0;
      dj_val  = cdb_alu_value;
    end else if (disp_qj_valid && cdb_lsb_valid && disp_qj == cdb_lsb_rob) begin
      dj_pend = 1'b0;
      dj_val  = cdb_lsb_value;
    end
    if (disp_qk_valid && cdb_alu_valid && disp_qk == cdb_alu_rob) begin
      dk_pend = 1'b0;
      dk_val  = cdb_alu_value;
    end else if (disp_qk_valid && cdb_lsb_valid && disp_qk == cdb_lsb_rob) begin
      dk_pend = 1'b0;
      dk_val  = cdb_lsb_value;
    end
  end

  always_comb begin
    busy_d = busy_q;
    qjv_d  = qjv_q;
    qkv_d  = qkv_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    rob_d  = rob_q;
    count_d      = count_q;
    alu_sgn_d    = 1'b0;
    alu_opcode_d = alu_opcode_q;
    alu_lhs_d    = alu_lhs_q;
    alu_rhs_d    = alu_rhs_q;
    alu_imm_d    = alu_imm_q;
    alu_pc_d     = alu_pc_q;
    alu_rob_d    = alu_rob_q;

    if (flush) begin
      busy_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy_q[i] && qjv_q[i]) begin
          if (cdb_alu_valid && qj_q[i] == cdb_alu_rob) begin
            qjv_d[i] = 1'b0;
            vj_d[i]  = cdb_alu_value;
          end else if (cdb_lsb_valid && qj_q[i] == cdb_lsb_rob) begin
            qjv_d[i] = 1'b0;
            vj_d[i]  = cdb_lsb_value;
          end
        end
        if (busy_q[i] && qkv_q[i]) begin
          if (cdb_alu_valid && qk_q[i] == cdb_alu_rob) begin
            qkv_d[i] = 1'b0;
            vk_d[i]  = cdb_alu_value;
          end else if (cdb_lsb_valid && qk_q[i] == cdb_lsb_rob) begin
            qkv_d[i] = 1'b0;
            vk_d[i]  = cdb_lsb_value;
          end
        end
      end

      if (issue) begin
        busy_d[rdy_idx] = 1'b0;
        alu_sgn_d       = 1'b1;
        alu_opcode_d    = op_q[rdy_idx];
        alu_lhs_d       = vj_q[rdy_idx];
        alu_rhs_d       = vk_q[rdy_idx];
        alu_imm_d       = imm_q[rdy_idx];
        alu_pc_d        = pc_q[rdy_idx];
        alu_rob_d       = rob_q[rdy_idx];
      end

      // free_idx is drawn from pre-edge busy, so it never aliases the issued slot.
      if (accept) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = disp_opcode;
        vj_d[free_idx]   = dj_val;
        vk_d[free_idx]   = dk_val;
        qjv_d[free_idx]  = dj_pend;
        qkv_d[free_idx]  = dk_pend;
        qj_d[free_idx]   = disp_qj;
        qk_d[free_idx]   = disp_qk;
        imm_d[free_idx]  = disp_imm;
        pc_d[free_idx]   = disp_pc;
        rob_d[free_idx]  = disp_rob;
      end

      count_d = count_q + CW'(accept) - CW'(issue);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      qjv_q  <= '0;
      qkv_q  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      count_q      <= '0;
      alu_sgn_q    <= 1'b0;
      alu_opcode_q <= '0;
      alu_lhs_q    <= '0;
      alu_rhs_q    <= '0;
      alu_imm_q    <= '0;
      alu_pc_q     <= '0;
      alu_rob_q    <= '0;
    end else begin
      busy_q       <= busy_d;
      qjv_q        <= qjv_d;
      qkv_q        <= qkv_d;
      op_q         <= op_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
      imm_q        <= imm_d;
      pc_q         <= pc_d;
      rob_q        <= rob_d;
      count_q      <= count_d;
      alu_sgn_q    <= alu_sgn_d;
      alu_opcode_q <= alu_opcode_d;
      alu_lhs_q    <= alu_lhs_d;
      alu_rhs_q    <= alu_rhs_d;
      alu_imm_q    <= alu_imm_d;
      alu_pc_q     <= alu_pc_d;
      alu_rob_q    <= alu_rob_d;
    end
  end

  assign alu_sgn    = alu_sgn_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_lhs    = alu_lhs_q;
  assign alu_rhs    = alu_rhs_q;
  assign alu_imm    = alu_imm_q;
  assign alu_pc     = alu_pc_q;
  assign alu_rob    = alu_rob_q;

endmodule

// File: doc/rs_alu_issue.md
# rs_alu_issue

Reservation station feeding the integer ALU in the out-of-order core. It accepts decoded ALU/branch/jump micro-ops from dispatch, holds them until both source operands are valid, and snoops the two CDB buses (ALU and LSB) for the ROB tags it waits on. It issues at most one ready entry per cycle to the ALU's RS-side input (`RS_sgn`, `RS_opcode`, `lhs`, `rhs`, `imm`, `pc`, `ROB_entry`) through registered outputs.

## Interface
- `ENTRIES`, 8: number of station slots (power of two, at least 2).
- `ROB_W`, 4: ROB tag width.
- `clk` input 1: the only clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rdy` input 1: global enable; when low, state holds (see Timing).
- `flush` input 1: misprediction clear.
- `disp_valid` input 1: dispatch micro-op present this cycle.
- `disp_opcode` input 6: opcode code from the shared defines.
- `disp_vj`, `disp_vk` input 32: operand values, meaningful when the matching q-valid bit is 0.
- `disp_qj_valid`, `disp_qk_valid` input 1: operand still pending.
- `disp_qj`, `disp_qk` input ROB_W: producer tags.
- `disp_imm`, `disp_pc` input 32: immediate and instruction PC.
- `disp_rob` input ROB_W: destination ROB tag.
- `full` output 1: no free slot. Combinational from registered occupancy.
- `cdb_alu_valid`, `cdb_lsb_valid` input 1: broadcast valid.
- `cdb_alu_rob`, `cdb_lsb_rob` input ROB_W: broadcast tag.
- `cdb_alu_value`, `cdb_lsb_value` input 32: broadcast data.
- `alu_sgn` output 1: issue strobe to the ALU. Registered.
- `alu_opcode` output 6, `alu_lhs`/`alu_rhs`/`alu_imm`/`alu_pc` output 32, `alu_rob` output ROB_W: issued operands. Registered.

## Operation
- Each entry holds: busy, opcode, vj, vk, qj_valid, qj, qk_valid, qk, imm, pc, rob.
- An entry is ready when busy=1, qj_valid=0 and qk_valid=0.
- **Dispatch:** accepted when `disp_valid & ~full & rdy & ~flush`. It writes the lowest-index free slot.
  - Dispatch-cycle bypass: if `disp_qj_valid` and a CDB bus carries a matching tag this cycle, store that value with qj_valid=0. The same rule applies to k.
  - If both buses match, the ALU bus wins.
  - `disp_valid` while `full` is dropped silently. This is a protocol error.
- **Wake-up:** each busy entry compares qj and qk against both CDB tags every cycle. On a match it captures the value and clears the q-valid bit at the edge.
- **Select:** the lowest-index ready entry is selected. At the edge it is copied to the alu_* outputs with alu_sgn=1, and its busy bit is cleared. If no entry is ready, alu_sgn=0 and the other alu_* outputs hold their last values.
- **Occupancy counter:** `count` is 0..ENTRIES. It changes by +dispatch −issue, so a simultaneous dispatch and issue leaves it unchanged. `full` = (count==ENTRIES).
- A slot freed by an issue is not reusable by a dispatch in the same cycle. The free slot is chosen from pre-edge state.

## Timing
- **Reset (rst=0, asynchronous):** all busy=0, count=0, alu_sgn=0, alu_opcode=0, alu_lhs=alu_rhs=alu_imm=alu_pc=0, alu_rob=0. Consequently `full`=0.
- **Latency:**
  - Dispatch with ready operands at edge N → alu_sgn=1 during the cycle after edge N+1.
  - CDB broadcast in cycle C wakes an entry at the end of C → issue strobe one cycle later.
  - Bypassed dispatch has the same latency as ready dispatch.
- **Issue rate:** alu_sgn is high for exactly one cycle per issued entry. Back-to-back issues are allowed every cycle.
- **rdy=0:** entries, count and alu_* data hold. alu_sgn is forced to 0 at the edge so the ALU does not rebroadcast. CDB inputs are ignored.
- **flush=1:** at the edge, all busy=0, count=0, alu_sgn=0. Any dispatch that cycle is discarded. Flush acts regardless of rdy. Only rst has higher priority.
- **Reset mid-operation:** all pending entries are lost. No output glitch beyond the asynchronous clear.

## Structure
- The shared defines header holds the opcode codes (ADD…JALR), the ROB tag width default, and the entry-count default.
- One sub-module, `rs_pick`: a parameterized lowest-index one-hot/encoded priority picker returning found + index. It is instantiated twice: once for the free slot and once for the ready slot.

## Test plan
- **Ready dispatch:** reset, then dispatch ADD vj=5, vk=7, rob=3 → alu_sgn=1 two edges later with alu_lhs=5, alu_rhs=7, alu_rob=3; `full`=0 throughout.
- **Wake-up:** dispatch SUB with qj_valid=1, qj=2; hold 4 cycles → no issue. Then cdb_lsb_valid, tag 2, value 100 → issue one cycle after the wake-up edge with alu_lhs=100.
- **Dispatch-cycle bypass:** dispatch with qk=6 while cdb_alu carries tag 6, value 0xDEAD and cdb_lsb carries tag 6, value 0xBEEF → issued alu_rhs=0xDEAD.
- **Fill and stall:** dispatch 8 entries all waiting on tag 1 → `full`=1 and a 9th dispatch is dropped. Broadcast tag 1 → 8 consecutive alu_sgn pulses in slot order 0..7, and count returns to 0.
- **Flush:** with 3 ready and 2 waiting entries, assert flush for one cycle → alu_sgn=0 afterwards, count=0, no further issues.
- **rdy gating:** with 2 ready entries, drop rdy for 3 cycles → alu_sgn=0 and the entries are retained. Raise rdy → both entries issue on consecutive cycles.
